keccak_obytes_gearbox: RTL

Receive-side consumer of the Keccak output byte stream. It accepts 64-bit squeeze words from the Keccak core with a valid/ready handshake. It repacks the bytes into 3-byte groups, the unit consumed by Kyber rejection sampling (two 12-bit candidates per group). It sits between the Keccak squeeze port and the sampler, absorbing rate mismatch in a 16-byte shift buffer.

---
 rtl/keccak_obytes_gearbox.sv | 100 ++++++++++
 1 files changed

// File: rtl/keccak_obytes_gearbox.sv
// Repacks 64-bit Keccak squeeze words into 3-byte groups for Kyber rejection sampling.
// States: IDLE (wait for i_start) | RUN (accept words, emit groups) | DONE (one-cycle end pulse)
module keccak_obytes_gearbox #(
  parameter int BW_DATA = 64,
  parameter int BW_LEN  = 10
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [BW_LEN-1:0]  i_len,
  input  logic [BW_DATA-1:0] i_words,
  input  logic               i_words_valid,
  output logic               o_words_ready,
  output logic [23:0]        o_grp,
  output logic               o_grp_valid,
  input  logic               i_grp_ready,
  output logic               o_done,
  output logic [1:0]         o_drop
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [BW_LEN-1:0] rem_q, rem_d;
  logic [127:0]      buf_q, buf_d;

  logic         in_run, acc, emit;
  logic [3:0]   take;
  logic [4:0]   cnt_sh;
  logic [63:0]  word_m;
  logic [127:0] buf_sh, word_ext;

  assign in_run        = (state_q == S_RUN);
  assign o_words_ready = in_run && (cnt_q <= 5'd8) && (rem_q != '0);
  assign o_grp_valid   = in_run && (cnt_q >= 5'd3);
  assign o_grp         = buf_q[127:104];
  assign o_done        = (state_q == S_DONE);
  assign o_drop        = o_done ? cnt_q[1:0] : 2'd0;
  assign acc           = i_words_valid && o_words_ready;
  assign emit          = o_grp_valid && i_grp_ready;

  always_comb begin
    take   = (rem_q >= BW_LEN'(8)) ? 4'd8 : rem_q[3:0];
    // keep only the top 'take' bytes; bytes past the stream end are zeroed
    word_m = i_words[63:0] & ({64{1'b1}} << {4'd8 - take, 3'b000});
    buf_sh = emit ? {buf_q[103:0], 24'd0} : buf_q;
    cnt_sh = emit ? (cnt_q - 5'd3) : cnt_q;
    // cnt_sh <= 8 whenever a word is accepted, so the new bytes always fit
    word_ext = {word_m, 64'd0} >> {cnt_sh[3:0], 3'b000};

    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    buf_d   = buf_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          rem_d   = i_len;
          cnt_d   = 5'd0;
          buf_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if ((rem_q == '0) && (cnt_q < 5'd3)) begin
          state_d = S_DONE;
        end else begin
          buf_d = acc ? (buf_sh | word_ext) : buf_sh;
          cnt_d = cnt_sh + (acc ? {1'b0, take} : 5'd0);
          if (acc) rem_d = rem_q - BW_LEN'(take);
        end
      end
      S_DONE: begin
        cnt_d   = 5'd0;
        buf_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
    end
  end

endmodule
